// File: rtl/seq_div_pkg.sv
// Shared definitions for the seq_div restoring divider: FSM state encoding
// and the counter-width helper.
package seq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2: number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) n++;
    return n;
  endfunction

endpackage

// File: rtl/seq_div_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module div_step #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH:0]   prem,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] nrem,
  output logic                 qbit
);

  logic [DATAWIDTH-1:0] diff;

  // The compare keeps the carry bit; the difference fits in DATAWIDTH bits
  // whenever it is kept, because it is then smaller than the divisor.
  always_comb begin
    qbit = (prem >= {1'b0, divisor});
    diff = prem[DATAWIDTH-1:0] - divisor;
    nrem = qbit ? diff : prem[DATAWIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement (truncating) division.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 busy,
  output logic                 done,
  output logic                 divzero
);

  localparam int             CW       = clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(DATAWIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [DATAWIDTH-1:0] dvd, dvs, prem, qsh;
  logic [DATAWIDTH-1:0] a_mag, b_mag;
  logic [DATAWIDTH-1:0] step_rem, quot_mag, quot_fix, rem_fix;
  logic                 step_q, accept, last, b_zero;

`ifdef SEQ_DIV_SIGNED_EN
  logic q_neg, r_neg;

  function automatic logic [DATAWIDTH-1:0] magnitude(input logic signed [DATAWIDTH-1:0] v);
    return v[DATAWIDTH-1] ? -v : v;
  endfunction

  function automatic logic [DATAWIDTH-1:0] apply_sign(input logic [DATAWIDTH-1:0] m,
                                                      input logic             neg);
    return neg ? -m : m;
  endfunction

  assign a_mag    = magnitude($signed(a));
  assign b_mag    = magnitude($signed(b));
  assign quot_fix = apply_sign(quot_mag, q_neg);
  assign rem_fix  = apply_sign(step_rem, r_neg);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
      r_neg <= a[DATAWIDTH-1];
    end
  end
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign quot_fix = quot_mag;
  assign rem_fix  = step_rem;
`endif

  assign b_zero   = (b == '0);
  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign last     = (state == ST_CALC) && (cnt == CNT_LAST);
  assign quot_mag = {qsh[DATAWIDTH-2:0], step_q};
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  div_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .prem    ({prem, dvd[DATAWIDTH-1]}),
    .divisor (dvs),
    .nrem    (step_rem),
    .qbit    (step_q)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = b_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE: begin
        if (start) state_nxt = b_zero ? ST_DONE : ST_CALC;
        else       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-bit iteration and result write-back.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      qsh     <= '0;
      quot    <= '0;
      rem     <= '0;
      divzero <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      dvd     <= a_mag;
      dvs     <= b_mag;
      prem    <= '0;
      qsh     <= '0;
      divzero <= b_zero;
      if (b_zero) begin
        quot <= '1;
        rem  <= a;
      end
    end else if (state == ST_CALC) begin
      cnt  <= cnt - CNT_LAST;
      dvd  <= {dvd[DATAWIDTH-2:0], 1'b0};
      prem <= step_rem;
      qsh  <= quot_mag;
      if (last) begin
        quot <= quot_fix;
        rem  <= rem_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (DATAWIDTH=16): directed cases plus
// randomized operands checked against an arithmetic reference model.
module tb_seq_div;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         start;
  logic [W-1:0] a, b, quot, rem;
  logic         busy, done, divzero;

  int checks = 0;
  int passed = 0;

  seq_div #(.DATAWIDTH(W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .quot    (quot),
    .rem     (rem),
    .busy    (busy),
    .done    (done),
    .divzero (divzero)
  );

  always #5 Clk = ~Clk;

  task automatic check_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: plain division; divide-by-zero yields all ones and the dividend.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] q, r;
`ifdef SEQ_DIV_SIGNED_EN
    int sa, sb, tq, tr;
`endif
    if (bv == '0) begin
      q = '1;
      r = av;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sa = int'($signed(av));
      sb = int'($signed(bv));
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[W-1:0];
      r  = tr[W-1:0];
`else
      q = av / bv;
      r = av % bv;
`endif
    end
    return {q, r};
  endfunction

  // Called #1 after an edge; returns #1 after the edge that accepts start.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the one right after the accepting edge.
  task automatic await_done(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (!done && n <= exp_lat + 4) begin
      check_b({tag, " busy"}, busy, 1'b1);
      @(posedge Clk);
      #1;
      n++;
    end
    check_i({tag, " latency"}, n, exp_lat);
    check_b({tag, " busy at done"}, busy, 1'b1);
  endtask

  initial begin
    int           dones, dcyc;
    logic [W-1:0] cq, cr, av, bv, eq, er;
    logic [31:0]  rnd;
    logic [2*W-1:0] exp_qr;

    Rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check_v("reset quot", quot, '0);
    check_v("reset rem", rem, '0);
    check_b("reset busy", busy, 1'b0);
    check_b("reset done", done, 1'b0);
    check_b("reset divzero", divzero, 1'b0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    launch(16'd100, 16'd7);
    await_done("100/7", W + 1);
    check_v("100/7 quot", quot, 16'd14);
    check_v("100/7 rem", rem, 16'd2);
    check_b("100/7 divzero", divzero, 1'b0);
    @(posedge Clk);
    #1;
    check_b("done pulse width", done, 1'b0);
    check_b("idle busy", busy, 1'b0);

    launch(16'hFFFF, 16'd1);
    await_done("ffff/1", W + 1);
    check_v("ffff/1 quot", quot, 16'hFFFF);
    check_v("ffff/1 rem", rem, 16'd0);
    launch(16'd3, 16'd10);
    check_b("back-to-back busy", busy, 1'b1);
    check_b("back-to-back done low", done, 1'b0);
    await_done("3/10", W + 1);
    check_v("3/10 quot", quot, 16'd0);
    check_v("3/10 rem", rem, 16'd3);

    repeat (2) begin @(posedge Clk); #1; end
    launch(16'd5, 16'd0);
    await_done("5/0", 1);
    check_v("5/0 quot", quot, 16'hFFFF);
    check_v("5/0 rem", rem, 16'd5);
    check_b("5/0 divzero", divzero, 1'b1);
    repeat (3) begin @(posedge Clk); #1; end
    check_b("divzero holds", divzero, 1'b1);
    check_v("quot holds", quot, 16'hFFFF);
    launch(16'd7, 16'd2);
    check_b("divzero cleared on start", divzero, 1'b0);
    await_done("7/2", W + 1);
    check_v("7/2 quot", quot, 16'd3);
    check_v("7/2 rem", rem, 16'd1);

    @(posedge Clk);
    #1;
    launch(16'd1000, 16'd3);
    dones = 0;
    dcyc = 0;
    cq = '0;
    cr = '0;
    for (int c = 1; c <= 24; c++) begin
      if (done) begin
        dones++;
        dcyc = c;
        cq = quot;
        cr = rem;
      end
      if (c == 4) begin
        start = 1'b1;
        a = 16'd9;
        b = 16'd9;
      end
      if (c == 5) start = 1'b0;
      @(posedge Clk);
      #1;
    end
    check_i("ignored start done count", dones, 1);
    check_i("ignored start done cycle", dcyc, W + 1);
    check_v("1000/3 quot", cq, 16'd333);
    check_v("1000/3 rem", cr, 16'd1);

    launch(16'd500, 16'd4);
    repeat (6) begin @(posedge Clk); #1; end
    @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    check_v("abort quot", quot, '0);
    check_v("abort rem", rem, '0);
    check_b("abort busy", busy, 1'b0);
    check_b("abort done", done, 1'b0);
    check_b("abort divzero", divzero, 1'b0);
    #2;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    dones = 0;
    for (int c = 0; c < 24; c++) begin
      if (done) dones++;
      @(posedge Clk);
      #1;
    end
    check_i("abort no done", dones, 0);
    launch(16'd8, 16'd2);
    await_done("8/2", W + 1);
    check_v("8/2 quot", quot, 16'd4);
    check_v("8/2 rem", rem, 16'd0);

`ifdef SEQ_DIV_SIGNED_EN
    launch(16'hFFF9, 16'd2);
    await_done("-7/2", W + 1);
    check_v("-7/2 quot", quot, 16'hFFFD);
    check_v("-7/2 rem", rem, 16'hFFFF);
    launch(16'h8000, 16'hFFFF);
    await_done("min/-1", W + 1);
    check_v("min/-1 quot", quot, 16'h8000);
    check_v("min/-1 rem", rem, 16'h0000);
`endif

    for (int i = 0; i < 30; i++) begin
      rnd = $urandom;
      av = rnd[W-1:0];
      rnd = $urandom;
      case ($urandom_range(0, 4))
        0:       bv = '0;
        1:       bv = W'($urandom_range(1, 15));
        2:       bv = 16'h8000 | rnd[W-1:0];
        default: bv = rnd[W-1:0];
      endcase
      exp_qr = ref_div(av, bv);
      eq = exp_qr[2*W-1:W];
      er = exp_qr[W-1:0];
      launch(av, bv);
      await_done("random", (bv == '0) ? 1 : W + 1);
      check_v("random quot", quot, eq);
      check_v("random rem", rem, er);
      check_b("random divzero", divzero, bv == '0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge Clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
